// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file geometry and arbiter FSM encodings for rf_write_arbiter.
package rf_write_arbiter_pkg;
  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 8;

  localparam logic [RF_ADDR_W-1:0] CLR_FIRST = RF_ADDR_W'(1);
  localparam logic [RF_ADDR_W-1:0] CLR_LAST  = RF_ADDR_W'(RF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR_START = 2'd0,
    ST_CLEAR       = 2'd1,
    ST_RUN         = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, modulo NREQ.
module rr_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] gnt_id_o,
  output logic             gnt_vld_o
);

  always_comb begin
    gnt_o     = '0;
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_vld_o && req_i[i] && (i == (int'(ptr_i) + off) % NREQ)) begin
          gnt_o[i]  = 1'b1;
          gnt_id_o  = PTR_W'(i);
          gnt_vld_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-port arbiter for the 8x16 register file: post-reset clear of r1..r7, then round-robin writeback.
// Optional RF_R0_DROP_EN: writes to r0 are acknowledged and discarded without taking an arbitration slot.
//
// state          | meaning
// ST_CLEAR_START | just out of reset, nothing driven to the RF yet
// ST_CLEAR       | writing zero to r1..r7, one register per cycle
// ST_RUN         | normal operation, requesters arbitrate for the write port
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic                        clk0,
  input  logic                        rstb0,
  input  logic                        core_en,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [RF_ADDR_W*NREQ-1:0]   req_addr,
  input  logic [RF_DATA_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic [RF_ADDR_W-1:0]        rf_tgt_addr,
  output logic [RF_DATA_W-1:0]        rf_tgt_data,
  output logic                        rf_werf,
  output logic                        rf_csb,
  output logic                        init_done,
  output logic [PTR_W-1:0]            grant_id
);

  arb_state_e             state_q, state_d;
  logic [RF_ADDR_W-1:0]   addr_q, addr_d;
  logic [RF_DATA_W-1:0]   data_q, data_d;
  logic                   werf_q, werf_d;
  logic                   csb_q, csb_d;
  logic                   done_q, done_d;
  logic [PTR_W-1:0]       gid_q, gid_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;

  logic [NREQ-1:0]        arb_req, r0_ack, gnt;
  logic [PTR_W-1:0]       win_id;
  logic                   win_vld, run_en, xfer;
  logic [RF_ADDR_W-1:0]   win_addr;
  logic [RF_DATA_W-1:0]   win_data;

`ifdef RF_R0_DROP_EN
  logic [NREQ-1:0] r0_req;

  always_comb begin
    r0_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      r0_req[i] = (req_addr[RF_ADDR_W*i +: RF_ADDR_W] == '0);
    end
  end

  // r0 writes are swallowed here, so they never consume a round-robin turn
  assign arb_req = req_valid & ~r0_req;
  assign r0_ack  = req_valid & r0_req;
`else
  assign arb_req = req_valid;
  assign r0_ack  = '0;
`endif

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i     (arb_req),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_id_o  (win_id),
    .gnt_vld_o (win_vld)
  );

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_addr = req_addr[RF_ADDR_W*i +: RF_ADDR_W];
        win_data = req_data[RF_DATA_W*i +: RF_DATA_W];
      end
    end
  end

  assign run_en    = (state_q == ST_RUN) && core_en;
  assign xfer      = run_en && win_vld;
  assign req_ready = run_en ? (gnt | r0_ack) : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    werf_d  = 1'b1;
    csb_d   = csb_q;
    done_d  = done_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR_START: begin
        state_d = ST_CLEAR;
        werf_d  = 1'b0;
        csb_d   = 1'b0;
        addr_d  = CLR_FIRST;
        data_d  = '0;
      end
      ST_CLEAR: begin
        werf_d = 1'b0;
        csb_d  = 1'b0;
        if (addr_q == CLR_LAST) begin
          state_d = ST_RUN;
          werf_d  = 1'b1;
          done_d  = 1'b1;
          csb_d   = ~core_en;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_RUN: begin
        csb_d = ~core_en;
        if (xfer) begin
          addr_d = win_addr;
          data_d = win_data;
          werf_d = 1'b0;
          gid_d  = win_id;
          ptr_d  = win_id;
        end
      end
      default: state_d = ST_CLEAR_START;
    endcase
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state_q <= ST_CLEAR_START;
      addr_q  <= '0;
      data_q  <= '0;
      werf_q  <= 1'b1;
      csb_q   <= 1'b1;
      done_q  <= 1'b0;
      gid_q   <= '0;
      ptr_q   <= PTR_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      werf_q  <= werf_d;
      csb_q   <= csb_d;
      done_q  <= done_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rf_tgt_addr = addr_q;
  assign rf_tgt_data = data_q;
  assign rf_werf     = werf_q;
  assign rf_csb      = csb_q;
  assign init_done   = done_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter with a behavioural RF and round-robin reference model.
module tb_rf_write_arbiter;
  localparam int NREQ  = 2;
  localparam int PTR_W = 1;
`ifdef RF_R0_DROP_EN
  localparam bit DROP_R0 = 1'b1;
`else
  localparam bit DROP_R0 = 1'b0;
`endif

  logic              clk0 = 1'b0;
  logic              rstb0 = 1'b0;
  logic              core_en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [3*NREQ-1:0] req_addr = '0;
  logic [16*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic [2:0]        rf_tgt_addr;
  logic [15:0]       rf_tgt_data;
  logic              rf_werf, rf_csb, init_done;
  logic [PTR_W-1:0]  grant_id;

  int checks = 0;
  int failures = 0;

  always #5 clk0 = ~clk0;

  rf_write_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
    .clk0        (clk0),
    .rstb0       (rstb0),
    .core_en     (core_en),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_tgt_addr (rf_tgt_addr),
    .rf_tgt_data (rf_tgt_data),
    .rf_werf     (rf_werf),
    .rf_csb      (rf_csb),
    .init_done   (init_done),
    .grant_id    (grant_id)
  );

  // Register file as seen from its pins: writes when selected and werf low, no reset.
  logic [15:0] rf_mem [8] = '{default: 16'hDEAD};
  always @(posedge clk0) if (!rf_werf && !rf_csb) rf_mem[rf_tgt_addr] <= rf_tgt_data;

  function automatic logic [15:0] rf_read(input logic [2:0] a);
    return (a == 3'd0) ? 16'h0000 : rf_mem[a];
  endfunction

  // Reference model state
  int               m_ptr;
  logic [2:0]       m_addr;
  logic [15:0]      m_data;
  logic [PTR_W-1:0] m_gid;
  logic             m_werf, m_csb;
  logic [15:0]      exp_mem [8];

  function automatic logic [NREQ-1:0] model_elig(input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] a);
    logic [NREQ-1:0] zero_dst;
    for (int i = 0; i < NREQ; i++) zero_dst[i] = (a[3*i +: 3] == 3'd0);
    return DROP_R0 ? (v & ~zero_dst) : v;
  endfunction

  function automatic int model_winner(input logic [NREQ-1:0] e, input int ptr);
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (ptr + off) % NREQ;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready(input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] a,
                                                  input logic ce, input int ptr);
    logic [NREQ-1:0] e, r;
    int w;
    if (!ce) return '0;
    e = model_elig(v, a);
    w = model_winner(e, ptr);
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r | (v & ~e);
  endfunction

  // Advance the model with the inputs currently applied, then step past the next edge.
  task automatic tick();
    logic [NREQ-1:0] e;
    int w;
    e = model_elig(req_valid, req_addr);
    w = model_winner(e, m_ptr);
    m_csb  = ~core_en;
    m_werf = 1'b1;
    if (core_en && w >= 0) begin
      m_addr = req_addr[3*w +: 3];
      m_data = req_data[16*w +: 16];
      m_gid  = PTR_W'(w);
      m_ptr  = w;
      m_werf = 1'b0;
      exp_mem[m_addr] = m_data;
    end
    @(posedge clk0);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    core_en = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if (rf_werf !== 1'b1) begin failures++; $display("FAIL reset_werf got=%b exp=1", rf_werf); end
    checks++; if (rf_csb !== 1'b1) begin failures++; $display("FAIL reset_csb got=%b exp=1", rf_csb); end
    checks++; if (rf_tgt_addr !== 3'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rf_tgt_addr); end
    checks++; if (rf_tgt_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", rf_tgt_data); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    req_valid = '0;
    core_en = 1'b0;
  endtask

  // Releases reset and walks the clear pass; abort_at>0 re-asserts reset after that clear write.
  task automatic test_clear_pass(input int abort_at);
    logic ce;
    @(negedge clk0);
    rstb0 = 1'b1;
    req_valid = '1;
    req_addr = {3'd2, 3'd6};
    req_data = {16'($urandom), 16'($urandom)};
    for (int e = 1; e <= 8; e++) begin
      ce = 1'($urandom_range(0, 1));
      core_en = ce;
      #1;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL clear_ready edge=%0d got=%b exp=00", e, req_ready); end
      @(posedge clk0);
      #1;
      if (e <= 7) begin
        checks++; if (rf_werf !== 1'b0) begin failures++; $display("FAIL clear_werf edge=%0d got=%b exp=0", e, rf_werf); end
        checks++; if (rf_csb !== 1'b0) begin failures++; $display("FAIL clear_csb edge=%0d got=%b exp=0", e, rf_csb); end
        checks++; if (rf_tgt_addr !== 3'(e)) begin failures++; $display("FAIL clear_addr edge=%0d got=%0d exp=%0d", e, rf_tgt_addr, e); end
        checks++; if (rf_tgt_data !== 16'h0) begin failures++; $display("FAIL clear_data edge=%0d got=%h exp=0000", e, rf_tgt_data); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL clear_init_done edge=%0d got=%b exp=0", e, init_done); end
        if (e == abort_at) begin
          rstb0 = 1'b0;
          #1;
          checks++; if (rf_werf !== 1'b1) begin failures++; $display("FAIL abort_werf got=%b exp=1", rf_werf); end
          checks++; if (rf_csb !== 1'b1) begin failures++; $display("FAIL abort_csb got=%b exp=1", rf_csb); end
          checks++; if (rf_tgt_addr !== 3'd0) begin failures++; $display("FAIL abort_addr got=%0d exp=0", rf_tgt_addr); end
          checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL abort_init_done got=%b exp=0", init_done); end
          req_valid = '0;
          core_en = 1'b0;
          return;
        end
      end else begin
        checks++; if (rf_werf !== 1'b1) begin failures++; $display("FAIL run_entry_werf got=%b exp=1", rf_werf); end
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL run_entry_init_done got=%b exp=1", init_done); end
        checks++; if (rf_csb !== ~ce) begin failures++; $display("FAIL run_entry_csb got=%b exp=%b", rf_csb, ~ce); end
      end
    end
    req_valid = '0;
    core_en = 1'b0;
    for (int a = 1; a < 8; a++) begin
      checks++; if (rf_read(3'(a)) !== 16'h0) begin failures++; $display("FAIL clear_rf r%0d got=%h exp=0000", a, rf_read(3'(a))); end
    end
    m_ptr = NREQ - 1;
    m_addr = 3'd7;
    m_data = 16'h0;
    m_gid = '0;
    m_werf = 1'b1;
    m_csb = 1'b1;
    for (int a = 0; a < 8; a++) exp_mem[a] = 16'h0;
  endtask

  task automatic test_single_write();
    core_en = 1'b1;
    req_valid = 2'b01;
    req_addr[2:0] = 3'd3;
    req_data[15:0] = 16'hA5A5;
    #2;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    tick();
    checks++; if (rf_tgt_addr !== 3'd3) begin failures++; $display("FAIL single_addr got=%0d exp=3", rf_tgt_addr); end
    checks++; if (rf_tgt_data !== 16'hA5A5) begin failures++; $display("FAIL single_data got=%h exp=a5a5", rf_tgt_data); end
    checks++; if (rf_werf !== 1'b0) begin failures++; $display("FAIL single_werf got=%b exp=0", rf_werf); end
    checks++; if (rf_csb !== 1'b0) begin failures++; $display("FAIL single_csb got=%b exp=0", rf_csb); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL single_grant_id got=%0d exp=0", grant_id); end
    req_valid = '0;
    tick();
    checks++; if (rf_werf !== 1'b1) begin failures++; $display("FAIL single_idle_werf got=%b exp=1", rf_werf); end
    checks++; if (rf_read(3'd3) !== 16'hA5A5) begin failures++; $display("FAIL single_rf r3 got=%h exp=a5a5", rf_read(3'd3)); end
  endtask

  task automatic test_alternate();
    logic [15:0] d4;
    int exp_id;
    d4 = 16'($urandom);
    core_en = 1'b1;
    req_valid = 2'b10;
    req_addr[5:3] = 3'd4;
    req_data[31:16] = d4;
    #2;
    tick();
    req_addr = {3'd2, 3'd1};
    req_data = {16'h2222, 16'h1111};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_id = k % 2;
      #2;
      checks++; if (req_ready !== ((exp_id == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL alt_ready k=%0d got=%b exp_id=%0d", k, req_ready, exp_id); end
      tick();
      checks++; if (grant_id !== 1'(exp_id)) begin failures++; $display("FAIL alt_grant_id k=%0d got=%0d exp=%0d", k, grant_id, exp_id); end
      checks++; if (rf_tgt_addr !== ((exp_id == 1) ? 3'd2 : 3'd1)) begin failures++; $display("FAIL alt_addr k=%0d got=%0d", k, rf_tgt_addr); end
      checks++; if (rf_tgt_data !== ((exp_id == 1) ? 16'h2222 : 16'h1111)) begin failures++; $display("FAIL alt_data k=%0d got=%h", k, rf_tgt_data); end
    end
    req_valid = '0;
    tick();
    checks++; if (rf_read(3'd1) !== 16'h1111) begin failures++; $display("FAIL alt_rf r1 got=%h exp=1111", rf_read(3'd1)); end
    checks++; if (rf_read(3'd2) !== 16'h2222) begin failures++; $display("FAIL alt_rf r2 got=%h exp=2222", rf_read(3'd2)); end
    checks++; if (rf_read(3'd4) !== d4) begin failures++; $display("FAIL alt_rf r4 got=%h exp=%h", rf_read(3'd4), d4); end
  endtask

  task automatic test_core_en_gate();
    req_valid = 2'b11;
    core_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #2;
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL gate_ready k=%0d got=%b exp=00", k, req_ready); end
      tick();
      checks++; if (rf_werf !== 1'b1) begin failures++; $display("FAIL gate_werf k=%0d got=%b exp=1", k, rf_werf); end
      checks++; if (rf_csb !== 1'b1) begin failures++; $display("FAIL gate_csb k=%0d got=%b exp=1", k, rf_csb); end
    end
    core_en = 1'b1;
    #2;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL gate_resume_ready got=%b exp=01", req_ready); end
    tick();
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL gate_resume_grant got=%0d exp=0", grant_id); end
    checks++; if (rf_csb !== 1'b0) begin failures++; $display("FAIL gate_resume_csb got=%b exp=0", rf_csb); end
    checks++; if (rf_werf !== 1'b0) begin failures++; $display("FAIL gate_resume_werf got=%b exp=0", rf_werf); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_r0_request();
    logic [15:0] d5;
    d5 = 16'($urandom);
    core_en = 1'b1;
    req_addr = {3'd0, 3'd5};
    req_data = {16'($urandom), d5};
    req_valid = 2'b11;
    #2;
`ifdef RF_R0_DROP_EN
    checks++; if (req_ready !== 2'b11) begin failures++; $display("FAIL r0_ready got=%b exp=11", req_ready); end
    tick();
    checks++; if (rf_tgt_addr !== 3'd5) begin failures++; $display("FAIL r0_addr got=%0d exp=5", rf_tgt_addr); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL r0_grant_id got=%0d exp=0", grant_id); end
`else
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL r0_ready got=%b exp=10", req_ready); end
    tick();
    checks++; if (rf_tgt_addr !== 3'd0) begin failures++; $display("FAIL r0_addr got=%0d exp=0", rf_tgt_addr); end
    checks++; if (grant_id !== 1'b1) begin failures++; $display("FAIL r0_grant_id got=%0d exp=1", grant_id); end
    req_valid = 2'b01;
    #2;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL r0_second_ready got=%b exp=01", req_ready); end
    tick();
    checks++; if (rf_tgt_addr !== 3'd5) begin failures++; $display("FAIL r0_second_addr got=%0d exp=5", rf_tgt_addr); end
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL r0_second_grant got=%0d exp=0", grant_id); end
`endif
    checks++; if (rf_werf !== 1'b0) begin failures++; $display("FAIL r0_werf got=%b exp=0", rf_werf); end
    req_valid = '0;
    tick();
    checks++; if (rf_read(3'd5) !== d5) begin failures++; $display("FAIL r0_rf r5 got=%h exp=%h", rf_read(3'd5), d5); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pv, exp_rdy;
    logic [2:0]      pa [NREQ];
    logic [15:0]     pd [NREQ];
    int              waitc [NREQ];
    pv = '0;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = 3'd0;
      pd[i] = 16'h0;
      waitc[i] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 6) begin
          pv[i] = 1'b1;
          pa[i] = 3'($urandom_range(0, 7));
          pd[i] = 16'($urandom);
          waitc[i] = 0;
        end
      end
      core_en = ($urandom_range(0, 7) != 0);
      req_valid = pv;
      for (int i = 0; i < NREQ; i++) begin
        req_addr[3*i +: 3] = pa[i];
        req_data[16*i +: 16] = pd[i];
      end
      #2;
      exp_rdy = model_ready(req_valid, req_addr, core_en, m_ptr);
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
      for (int i = 0; i < NREQ; i++) begin
        if (pv[i] && !req_ready[i] && (req_ready != '0)) begin
          waitc[i]++;
          checks++; if (waitc[i] >= NREQ) begin failures++; $display("FAIL rand_starve cyc=%0d req=%0d waited=%0d limit=%0d", cyc, i, waitc[i], NREQ - 1); end
        end
      end
      tick();
      checks++; if (rf_werf !== m_werf) begin failures++; $display("FAIL rand_werf cyc=%0d got=%b exp=%b", cyc, rf_werf, m_werf); end
      checks++; if (rf_csb !== m_csb) begin failures++; $display("FAIL rand_csb cyc=%0d got=%b exp=%b", cyc, rf_csb, m_csb); end
      checks++; if (rf_tgt_addr !== m_addr) begin failures++; $display("FAIL rand_addr cyc=%0d got=%0d exp=%0d", cyc, rf_tgt_addr, m_addr); end
      checks++; if (rf_tgt_data !== m_data) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, rf_tgt_data, m_data); end
      checks++; if (grant_id !== m_gid) begin failures++; $display("FAIL rand_grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, m_gid); end
      pv = pv & ~exp_rdy;
    end
    req_valid = '0;
    core_en = 1'b1;
    tick();
    for (int a = 1; a < 8; a++) begin
      checks++; if (rf_read(3'(a)) !== exp_mem[a]) begin failures++; $display("FAIL rand_rf r%0d got=%h exp=%h", a, rf_read(3'(a)), exp_mem[a]); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] old6;
    old6 = exp_mem[6];
    core_en = 1'b1;
    req_valid = 2'b01;
    req_addr[2:0] = 3'd6;
    req_data[15:0] = ~old6;
    #2;
    tick();
    checks++; if (rf_werf !== 1'b0) begin failures++; $display("FAIL midrun_pre_werf got=%b exp=0", rf_werf); end
    rstb0 = 1'b0;
    #1;
    checks++; if (rf_werf !== 1'b1) begin failures++; $display("FAIL midrun_werf got=%b exp=1", rf_werf); end
    checks++; if (rf_tgt_addr !== 3'd0) begin failures++; $display("FAIL midrun_addr got=%0d exp=0", rf_tgt_addr); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL midrun_init_done got=%b exp=0", init_done); end
    checks++; if (rf_csb !== 1'b1) begin failures++; $display("FAIL midrun_csb got=%b exp=1", rf_csb); end
    req_valid = '0;
    @(posedge clk0);
    #1;
    checks++; if (rf_read(3'd6) !== old6) begin failures++; $display("FAIL midrun_drop r6 got=%h exp=%h", rf_read(3'd6), old6); end
  endtask

  task automatic test_reset_mid_clear();
    test_clear_pass(4);
    @(posedge clk0);
    #1;
    checks++; if (rf_tgt_addr !== 3'd0) begin failures++; $display("FAIL midclear_hold_addr got=%0d exp=0", rf_tgt_addr); end
    test_clear_pass(0);
    core_en = 1'b1;
    req_addr = {3'd7, 3'd6};
    req_data = {16'h7777, 16'h6666};
    req_valid = 2'b11;
    #2;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midclear_ptr_ready got=%b exp=01", req_ready); end
    tick();
    checks++; if (grant_id !== 1'b0) begin failures++; $display("FAIL midclear_grant got=%0d exp=0", grant_id); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb0 = 1'b0;
    repeat (2) @(posedge clk0);
    #1;
    test_reset();
    test_clear_pass(0);
    test_single_write();
    test_alternate();
    test_core_en_gate();
    test_r0_request();
    test_random();
    test_reset_mid_run();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
